// File: rtl/audio_sd_pkg.sv
// rtl/audio_sd_pkg.sv - shared state encoding and sample helpers for the sigma-delta DAC
package audio_sd_pkg;

   // Ramp/run controller states shared by every channel
   typedef enum logic [1:0] {
      ST_RAMP_UP   = 2'd0,
      ST_RUN       = 2'd1,
      ST_RAMP_DOWN = 2'd2,
      ST_IDLE      = 2'd3
   } sd_state_t;

   // Mid-scale (silence) code for an offset-binary sample of the given width
   function automatic logic [31:0] mid_value(input int width);
      return 32'd1 << (width - 1);
   endfunction

   // Two's-complement to offset-binary: flip the sample MSB
   function automatic logic [31:0] signed_to_offset(input logic [31:0] sample, input int width);
      return sample ^ (32'd1 << (width - 1));
   endfunction

endpackage

// File: rtl/sd_modulator.sv
// rtl/sd_modulator.sv - single-channel first- or second-order sigma-delta modulator
module sd_modulator #(
   parameter int WIDTH = 16,
   parameter int ORDER = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] v,
   output logic             q
);

   logic r_q;

   assign q = r_q;

   generate
      if (ORDER == 1) begin : g_first
         // Only the low WIDTH bits of the accumulator persist; its carry bit is r_q
         logic [WIDTH-1:0] r_acc;
         logic [WIDTH:0]   w_acc_next;

         assign w_acc_next = {1'b0, r_acc} + {1'b0, v};

         // Carry-out accumulator: the carry is the output bit
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_acc <= '0;
               r_q   <= 1'b0;
            end else begin
               r_acc <= w_acc_next[WIDTH-1:0];
               r_q   <= w_acc_next[WIDTH];
            end
         end
      end else begin : g_second
         localparam int IW = WIDTH + 4;
         localparam int EW = WIDTH + 6;

         logic signed [IW-1:0] r_i1, r_i2;
         logic signed [IW-1:0] w_i1_next, w_i2_next;
         logic signed [EW-1:0] w_fb, w_sum1, w_sum2;

         // Clamp a wide sum into the integrator range instead of wrapping
         function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] x);
            if ((&x[EW-1:IW-1]) || !(|x[EW-1:IW-1]))
               return x[IW-1:0];
            else if (x[EW-1])
               return {1'b1, {(IW-1){1'b0}}};
            else
               return {1'b0, {(IW-1){1'b1}}};
         endfunction

         assign w_fb      = r_q ? $signed(EW'(1) << WIDTH) : '0;
         assign w_sum1    = EW'(r_i1) + $signed({6'b0, v}) - w_fb;
         assign w_i1_next = sat(w_sum1);
         assign w_sum2    = EW'(r_i2) + EW'(w_i1_next) - w_fb;
         assign w_i2_next = sat(w_sum2);

         // Two cascaded integrators with feedback from the registered output bit
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               r_i1 <= '0;
               r_i2 <= '0;
               r_q  <= 1'b0;
            end else begin
               r_i1 <= w_i1_next;
               r_i2 <= w_i2_next;
               r_q  <= ~w_i2_next[IW-1];
            end
         end
      end
   endgenerate

endmodule

// File: rtl/audio_sd_multichannel.sv
// rtl/audio_sd_multichannel.sv - multi-channel sigma-delta audio DAC with pop-free ramping
module audio_sd_multichannel
   import audio_sd_pkg::*;
#(
   parameter int CHANNELS  = 2,
   parameter int WIDTH     = 16,
   parameter int ORDER     = 1,
   parameter int SIGNED_IN = 0,
   parameter int RAMP_STEP = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CHANNELS*WIDTH-1:0] d,
   input  logic                      d_valid,
   input  logic                      terminate,
   output logic [CHANNELS-1:0]       q,
   output logic                      running,
   output logic                      idle
);

   localparam logic [WIDTH-1:0] MID  = WIDTH'(mid_value(WIDTH));
   localparam logic [WIDTH-1:0] STEP = WIDTH'(RAMP_STEP);

   logic [1:0]          r_rst_sync;
   logic                w_rst_n;
   sd_state_t           r_state, w_state_next;
   logic                r_running, r_idle;
   logic [CHANNELS-1:0] w_at_mid, w_at_zero, w_q_mod;

   // Assert reset immediately, release it two clocks later
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // Shared next-state decision across all channels
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_RAMP_UP:   if (terminate) w_state_next = ST_RAMP_DOWN;
                       else if (&w_at_mid) w_state_next = ST_RUN;
         ST_RUN:       if (terminate) w_state_next = ST_RAMP_DOWN;
         ST_RAMP_DOWN: if (!terminate) w_state_next = ST_RAMP_UP;
                       else if (&w_at_zero) w_state_next = ST_IDLE;
         default:      if (!terminate) w_state_next = ST_RAMP_UP;
      endcase
   end

   // State register with status flags that move on the same edge
   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state   <= ST_RAMP_UP;
         r_running <= 1'b0;
         r_idle    <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_running <= (w_state_next == ST_RUN);
         r_idle    <= (w_state_next == ST_IDLE);
      end
   end

   genvar ch;
   generate
      for (ch = 0; ch < CHANNELS; ch++) begin : g_ch
         logic [WIDTH-1:0] w_raw, w_sample, w_v_next, r_v;

         assign w_raw    = d[ch*WIDTH +: WIDTH];
         assign w_sample = (SIGNED_IN != 0) ? WIDTH'(signed_to_offset(32'(w_raw), WIDTH)) : w_raw;

         // Effective value: slew toward the target without jumps, or take a new sample
         always_comb begin
            w_v_next = r_v;
            case (r_state)
               ST_RAMP_UP: begin
                  if (r_v > MID)      w_v_next = (r_v - MID > STEP) ? r_v - STEP : MID;
                  else if (r_v < MID) w_v_next = (MID - r_v > STEP) ? r_v + STEP : MID;
               end
               ST_RUN:       if (d_valid && !terminate) w_v_next = w_sample;
               ST_RAMP_DOWN: w_v_next = (r_v > STEP) ? r_v - STEP : '0;
               default:      w_v_next = '0;
            endcase
         end

         // Effective value register
         always_ff @(posedge clk or negedge w_rst_n) begin
            if (!w_rst_n) r_v <= '0;
            else          r_v <= w_v_next;
         end

         assign w_at_mid[ch]  = (r_v == MID);
         assign w_at_zero[ch] = (r_v == '0);

         sd_modulator #(
            .WIDTH (WIDTH),
            .ORDER (ORDER)
         ) u_mod (
            .clk     (clk),
            .reset_n (w_rst_n),
            .v       (r_v),
            .q       (w_q_mod[ch])
         );
      end
   endgenerate

   // Silence the pins completely while parked at zero
   assign q       = w_q_mod & ~{CHANNELS{r_idle}};
   assign running = r_running;
   assign idle    = r_idle;

endmodule

// File: tb/tb_audio_sd_multichannel.sv
// tb/tb_audio_sd_multichannel.sv - directed vector bench for the sigma-delta DAC
module tb_audio_sd_multichannel;

   logic        clk = 1'b0;
   logic        reset_n, d_valid, terminate;
   logic [31:0] d1;
   logic [1:0]  q1;
   logic        running1, idle1;
   logic [15:0] d2;
   logic [0:0]  q2;
   logic        running2, idle2;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   audio_sd_multichannel #(
      .CHANNELS (2), .WIDTH (16), .ORDER (1), .SIGNED_IN (0), .RAMP_STEP (16)
   ) u_dut (
      .clk (clk), .reset_n (reset_n), .d (d1), .d_valid (d_valid),
      .terminate (terminate), .q (q1), .running (running1), .idle (idle1)
   );

   audio_sd_multichannel #(
      .CHANNELS (1), .WIDTH (16), .ORDER (2), .SIGNED_IN (1), .RAMP_STEP (16)
   ) u_dut2 (
      .clk (clk), .reset_n (reset_n), .d (d2), .d_valid (d_valid),
      .terminate (terminate), .q (q2), .running (running2), .idle (idle2)
   );

   typedef struct {
      logic [15:0] d0;
      logic [15:0] d1;
      logic [15:0] ds;
      int          n;
      int          e0;
      int          e1;
      int          es;
   } vec_t;

   task automatic check(input string name, input int act, input int exp, input int tol);
      n_vec++;
      if (act < exp - tol || act > exp + tol) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (tolerance %0d)", name, act, exp, tol);
      end
   endtask

   task automatic count_q(input int n, output int c0, output int c1, output int c2);
      c0 = 0; c1 = 0; c2 = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         c0 += int'(q1[0]);
         c1 += int'(q1[1]);
         c2 += int'(q2[0]);
      end
   endtask

   task automatic capture(input logic [31:0] v1, input logic [15:0] v2);
      @(negedge clk);
      d1 = v1; d2 = v2; d_valid = 1'b1;
      @(negedge clk);
      d_valid = 1'b0;
   endtask

   // sel: 0 = running1, 1 = idle1, 2 = running2; returns clocks waited (budget on timeout)
   task automatic wait_sig(input int sel, input int budget, output int cyc);
      logic s;
      cyc = 0;
      s = 1'b0;
      while (!s && cyc < budget) begin
         @(negedge clk);
         cyc++;
         s = (sel == 0) ? running1 : (sel == 1) ? idle1 : running2;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[5];
      int   c0, c1, c2, cyc;

      tbl[0] = '{16'h0000, 16'h8000, 16'h0000, 256,   0, 128, 128};
      tbl[1] = '{16'h4000, 16'hC000, 16'h4000, 256,  64, 192, 192};
      tbl[2] = '{16'h2000, 16'hE000, 16'hC000, 256,  32, 224,  64};
      tbl[3] = '{16'hFFFF, 16'h0001, 16'h6000, 256, 256,   0, 224};
      tbl[4] = '{16'h1000, 16'h7000, 16'hA000, 256,  16, 112,  32};

      reset_n = 1'b0; d_valid = 1'b0; terminate = 1'b0; d1 = '0; d2 = '0;
      repeat (3) @(negedge clk);
      check("reset_q1", int'(q1), 0, 0);
      check("reset_running1", int'(running1), 0, 0);
      check("reset_idle1", int'(idle1), 0, 0);
      check("reset_q2", int'(q2), 0, 0);

      // Ramp-up from reset, with captures offered that must be ignored
      d1 = 32'h0000_0000; d2 = 16'h8000; d_valid = 1'b1;
      reset_n = 1'b1;
      wait_sig(0, 3000, cyc);
      d_valid = 1'b0;
      check("rampup_clocks", cyc, 2049, 2);
      check("rampup_running2", int'(running2), 1, 0);
      count_q(64, c0, c1, c2);
      check("mid_ch0_density", c0, 32, 0);
      check("mid_ch1_density", c1, 32, 0);
      check("mid_o2_density", c2, 32, 5);

      // Steady-state density table
      for (int i = 0; i < 5; i++) begin
         capture({tbl[i].d1, tbl[i].d0}, tbl[i].ds);
         repeat (256) @(negedge clk);
         count_q(tbl[i].n, c0, c1, c2);
         check($sformatf("vec%0d_ch0", i), c0, tbl[i].e0, 1);
         check($sformatf("vec%0d_ch1", i), c1, tbl[i].e1, 1);
         check($sformatf("vec%0d_o2", i), c2, tbl[i].es, 5);
      end

      // Long-run density at three-quarter scale
      capture({16'h8000, 16'hC000}, 16'h4000);
      repeat (512) @(negedge clk);
      count_q(65536, c0, c1, c2);
      check("long_o1_c000", c0, 49152, 1);
      check("long_o1_8000", c1, 32768, 1);
      check("long_o2_c000", c2, 49152, 16);

      // Most negative signed sample is zero level
      capture({16'hF000, 16'hF000}, 16'h8000);
      repeat (512) @(negedge clk);
      count_q(512, c0, c1, c2);
      check("signed_min_o2", c2, 0, 0);
      check("f000_ch0_density", c0, 480, 1);

      // Terminate from RUN; a coincident capture must be ignored
      @(negedge clk);
      terminate = 1'b1; d_valid = 1'b1; d1 = 32'h0;
      @(negedge clk);
      d_valid = 1'b0;
      check("term_running_drop", int'(running1), 0, 0);
      wait_sig(1, 5000, cyc);
      check("rampdown_clocks", cyc + 1, 3841, 2);
      count_q(100, c0, c1, c2);
      check("idle_q_silent", c0 + c1, 0, 0);

      terminate = 1'b0;
      @(negedge clk);
      check("idle_drop", int'(idle1), 0, 0);
      wait_sig(0, 3000, cyc);
      check("rampup_from_idle", cyc + 1, 2050, 2);

      // Abort a ramp-down part way; ramp-up resumes from the current value
      capture({16'hF000, 16'hF000}, 16'h0000);
      repeat (4) @(negedge clk);
      terminate = 1'b1;
      repeat (100) @(negedge clk);
      terminate = 1'b0;
      wait_sig(0, 3000, cyc);
      check("abort_rampup_clocks", cyc, 1694, 2);

      // Asynchronous reset pulse mid-RUN
      capture({16'h8000, 16'h0000}, 16'h0000);
      repeat (4) @(negedge clk);
      cyc = 0;
      while (!q1[1] && cyc < 4) begin
         @(negedge clk);
         cyc++;
      end
      check("pre_reset_q1_high", int'(q1[1]), 1, 0);
      reset_n = 1'b0;
      #1;
      check("async_reset_q1", int'(q1), 0, 0);
      check("async_reset_running1", int'(running1), 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      wait_sig(0, 3000, cyc);
      check("rampup_after_pulse", cyc, 2049, 2);
      check("rampup_after_pulse2", int'(running2), 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
